// File: rtl/stopwatch_pkg.sv
// Shared types for the lap stopwatch: FSM state encoding and FIFO sizing helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STOP  = 2'd2,
        ST_CLEAR = 2'd3
    } state_t;

    function automatic int unsigned fifo_ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/lap_stopwatch_fifo.sv
// lap_fifo: synchronous show-ahead FIFO; head is read combinationally from storage.
module lap_fifo
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8,
    localparam int unsigned AW   = fifo_ptr_w(DEPTH),
    localparam int unsigned CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A push into a full FIFO is accepted only when a pop frees a slot the same cycle.
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_q];
    assign count_o = cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// Lap stopwatch: button edge detect, tick prescaler, run/stop FSM and lap FIFO.
// Optional count-down mode is built when STOPWATCH_COUNTDOWN_EN is defined.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 10,
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned LAP_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_stop,
    input  logic                         reset_btn,
    input  logic                         lap_btn,
    input  logic                         lap_rd,
    input  logic                         count_down,
    input  logic [CNT_W-1:0]             preset,
    output logic [CNT_W-1:0]             elapsed,
    output logic                         running,
    output logic [CNT_W-1:0]             lap_data,
    output logic                         lap_valid,
    output logic [$clog2(LAP_DEPTH):0]   lap_count,
    output logic                         lap_overflow,
    output logic                         done
);

    localparam int unsigned PW = $clog2(CLK_DIV);

    logic             start_q, reset_q, lap_q;
    logic             start_edge, reset_edge, lap_edge;
    state_t           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] elapsed_q, elapsed_d;
    logic             running_q, ovf_q, ovf_d, done_q, done_d;
    logic             down_mode, tick, zero_hold, last_tick;
    logic             lap_push, lap_full, lap_empty, flush;

    assign start_edge = start_stop & ~start_q;
    assign reset_edge = reset_btn & ~reset_q;
    assign lap_edge   = lap_btn & ~lap_q;

    assign tick      = (state_q == ST_RUN) && (presc_q == PW'(CLK_DIV - 1));
    assign zero_hold = down_mode && (elapsed_q == '0);
    assign last_tick = tick && down_mode && (elapsed_q == CNT_W'(1));
    assign lap_push  = lap_edge && (state_q == ST_RUN || state_q == ST_STOP);
    assign flush     = (state_q == ST_CLEAR);

`ifdef STOPWATCH_COUNTDOWN_EN
    logic down_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    down_q <= 1'b0;
        else if (state_q == ST_CLEAR) down_q <= count_down;
    end
    assign down_mode = down_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^{count_down, preset};
    assign down_mode  = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        elapsed_d = elapsed_q;
        done_d    = 1'b0;
        ovf_d     = ovf_q;
        if (lap_push && lap_full && !lap_rd) ovf_d = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                // In down mode with nothing left to count, a start goes straight to STOP.
                if (start_edge)      state_d = zero_hold ? ST_STOP : ST_RUN;
                else if (reset_edge) state_d = ST_CLEAR;
            end
            ST_RUN: begin
                presc_d = tick ? '0 : presc_q + PW'(1);
                if (tick) begin
                    if (!down_mode)     elapsed_d = elapsed_q + CNT_W'(1);
                    else if (!zero_hold) elapsed_d = elapsed_q - CNT_W'(1);
                end
                done_d = last_tick;
                if (start_edge)      state_d = ST_STOP;
                else if (reset_edge) state_d = ST_CLEAR;
                else if (last_tick)  state_d = ST_STOP;
            end
            ST_STOP: begin
                if (start_edge && !zero_hold) state_d = ST_RUN;
                else if (reset_edge)          state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                state_d = ST_IDLE;
                presc_d = '0;
                ovf_d   = 1'b0;
`ifdef STOPWATCH_COUNTDOWN_EN
                elapsed_d = count_down ? preset : '0;
`else
                elapsed_d = '0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q   <= 1'b0;
            reset_q   <= 1'b0;
            lap_q     <= 1'b0;
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            elapsed_q <= '0;
            running_q <= 1'b0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            start_q   <= start_stop;
            reset_q   <= reset_btn;
            lap_q     <= lap_btn;
            state_q   <= state_d;
            presc_q   <= presc_d;
            elapsed_q <= elapsed_d;
            running_q <= (state_d == ST_RUN);
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

    lap_fifo #(
        .DEPTH (LAP_DEPTH),
        .W     (CNT_W)
    ) u_lap_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (lap_push),
        .pop_i   (lap_rd),
        .data_i  (elapsed_q),
        .data_o  (lap_data),
        .full_o  (lap_full),
        .empty_o (lap_empty),
        .count_o (lap_count)
    );

    assign elapsed      = elapsed_q;
    assign running      = running_q;
    assign lap_valid    = !lap_empty;
    assign lap_overflow = ovf_q;
    assign done         = done_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch (CLK_DIV=10, CNT_W=8, LAP_DEPTH=4).
`timescale 1ns/1ps
module tb_lap_stopwatch;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0, reset_btn = 1'b0, lap_btn = 1'b0, lap_rd = 1'b0;
    logic       count_down = 1'b0;
    logic [7:0] preset = '0;
    logic [7:0] elapsed, lap_data;
    logic       running, lap_valid, lap_overflow, done;
    logic [2:0] lap_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lap_stopwatch #(.CLK_DIV(10), .CNT_W(8), .LAP_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .start_stop(start_stop), .reset_btn(reset_btn),
        .lap_btn(lap_btn), .lap_rd(lap_rd), .count_down(count_down), .preset(preset),
        .elapsed(elapsed), .running(running), .lap_data(lap_data), .lap_valid(lap_valid),
        .lap_count(lap_count), .lap_overflow(lap_overflow), .done(done)
    );

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_start();
        start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
    endtask

    task automatic press_reset();
        reset_btn = 1'b1; @(negedge clk); reset_btn = 1'b0;
    endtask

    task automatic press_lap();
        lap_btn = 1'b1; @(negedge clk); lap_btn = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start_stop = 1'b0; reset_btn = 1'b0; lap_btn = 1'b0; lap_rd = 1'b0;
        count_down = 1'b0; preset = '0;
        wait_n(2);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start_stop = 1'b1;
        wait_n(2);
        n_cmp++; if (elapsed !== 8'd0) begin n_err++; $display("FAIL reset_elapsed got %0d exp 0", elapsed); end
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL reset_running got %b exp 0", running); end
        n_cmp++; if (lap_valid !== 1'b0 || lap_count !== 3'd0) begin n_err++; $display("FAIL reset_fifo valid=%b count=%0d exp 0/0", lap_valid, lap_count); end
        n_cmp++; if (lap_overflow !== 1'b0 || done !== 1'b0 || lap_data !== 8'd0) begin n_err++; $display("FAIL reset_misc ovf=%b done=%b data=%0d exp 0/0/0", lap_overflow, done, lap_data); end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL held_btn_edge running got %b exp 1", running); end
        start_stop = 1'b0;
        do_reset();
    endtask

    task automatic test_run35();
        do_reset();
        press_start();
        wait_n(35);
        n_cmp++; if (elapsed !== 8'd3) begin n_err++; $display("FAIL run35_elapsed got %0d exp 3", elapsed); end
        n_cmp++; if (running !== 1'b1) begin n_err++; $display("FAIL run35_running got %b exp 1", running); end
    endtask

    task automatic test_pause();
        do_reset();
        press_start();
        wait_n(4);
        press_start();
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL pause_stopped running got %b exp 0", running); end
        wait_n(19);
        n_cmp++; if (elapsed !== 8'd0) begin n_err++; $display("FAIL pause_hold elapsed got %0d exp 0", elapsed); end
        press_start();
        wait_n(4);
        n_cmp++; if (elapsed !== 8'd0 || running !== 1'b1) begin n_err++; $display("FAIL pause_nine elapsed=%0d running=%b exp 0/1", elapsed, running); end
        wait_n(1);
        n_cmp++; if (elapsed !== 8'd1) begin n_err++; $display("FAIL pause_resume elapsed got %0d exp 1", elapsed); end
    endtask

    task automatic test_wrap();
        do_reset();
        press_start();
        wait_n(2559);
        n_cmp++; if (elapsed !== 8'd255) begin n_err++; $display("FAIL wrap_max elapsed got %0d exp 255", elapsed); end
        wait_n(1);
        n_cmp++; if (elapsed !== 8'd0) begin n_err++; $display("FAIL wrap_zero elapsed got %0d exp 0", elapsed); end
        n_cmp++; if (lap_overflow !== 1'b0 || done !== 1'b0 || running !== 1'b1) begin n_err++; $display("FAIL wrap_flags ovf=%b done=%b run=%b exp 0/0/1", lap_overflow, done, running); end
    endtask

    task automatic test_lap_overflow();
        logic [7:0] exp_v;
        do_reset();
        press_start();
        for (int k = 0; k < 5; k++) begin
            wait_n(9);
            press_lap();
            if (k == 0) begin
                n_cmp++; if (lap_valid !== 1'b1 || lap_count !== 3'd1 || lap_data !== 8'd0) begin n_err++; $display("FAIL lap_first valid=%b count=%0d data=%0d exp 1/1/0", lap_valid, lap_count, lap_data); end
            end
        end
        n_cmp++; if (lap_count !== 3'd4) begin n_err++; $display("FAIL lap_full count got %0d exp 4", lap_count); end
        n_cmp++; if (lap_overflow !== 1'b1) begin n_err++; $display("FAIL lap_ovf got %b exp 1", lap_overflow); end
        for (int i = 0; i < 4; i++) begin
            exp_v = 8'(i);
            n_cmp++; if (lap_data !== exp_v) begin n_err++; $display("FAIL lap_pop%0d data got %0d exp %0d", i, lap_data, exp_v); end
            lap_rd = 1'b1; @(negedge clk); lap_rd = 1'b0;
        end
        n_cmp++; if (lap_valid !== 1'b0 || lap_count !== 3'd0) begin n_err++; $display("FAIL lap_drained valid=%b count=%0d exp 0/0", lap_valid, lap_count); end
        lap_rd = 1'b1; @(negedge clk); lap_rd = 1'b0;
        n_cmp++; if (lap_count !== 3'd0 || lap_overflow !== 1'b1) begin n_err++; $display("FAIL lap_empty_pop count=%0d ovf=%b exp 0/1", lap_count, lap_overflow); end
        press_reset();
        wait_n(1);
        n_cmp++; if (lap_overflow !== 1'b0 || elapsed !== 8'd0 || running !== 1'b0) begin n_err++; $display("FAIL lap_clear ovf=%b elapsed=%0d run=%b exp 0/0/0", lap_overflow, elapsed, running); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_v;
        do_reset();
        press_start();
        for (int k = 0; k < 4; k++) begin
            wait_n(9);
            press_lap();
        end
        wait_n(9);
        lap_btn = 1'b1; lap_rd = 1'b1; @(negedge clk); lap_btn = 1'b0; lap_rd = 1'b0;
        n_cmp++; if (lap_count !== 3'd4 || lap_overflow !== 1'b0) begin n_err++; $display("FAIL fullpp_count count=%0d ovf=%b exp 4/0", lap_count, lap_overflow); end
        for (int i = 1; i < 5; i++) begin
            exp_v = 8'(i);
            n_cmp++; if (lap_data !== exp_v) begin n_err++; $display("FAIL fullpp_pop%0d data got %0d exp %0d", i, lap_data, exp_v); end
            lap_rd = 1'b1; @(negedge clk); lap_rd = 1'b0;
        end
    endtask

    task automatic test_start_reset_same();
        do_reset();
        press_start();
        wait_n(12);
        n_cmp++; if (elapsed !== 8'd1) begin n_err++; $display("FAIL both_pre elapsed got %0d exp 1", elapsed); end
        start_stop = 1'b1; reset_btn = 1'b1; @(negedge clk); start_stop = 1'b0; reset_btn = 1'b0;
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL both_stop running got %b exp 0", running); end
        wait_n(2);
        n_cmp++; if (elapsed !== 8'd1) begin n_err++; $display("FAIL both_kept elapsed got %0d exp 1", elapsed); end
        press_start();
        wait_n(6);
        n_cmp++; if (elapsed !== 8'd1 || running !== 1'b1) begin n_err++; $display("FAIL both_resume elapsed=%0d run=%b exp 1/1", elapsed, running); end
        wait_n(1);
        n_cmp++; if (elapsed !== 8'd2) begin n_err++; $display("FAIL both_tick elapsed got %0d exp 2", elapsed); end
    endtask

`ifdef STOPWATCH_COUNTDOWN_EN
    task automatic test_countdown();
        do_reset();
        count_down = 1'b1; preset = 8'd3;
        press_reset();
        wait_n(1);
        n_cmp++; if (elapsed !== 8'd3 || running !== 1'b0) begin n_err++; $display("FAIL cd_load elapsed=%0d run=%b exp 3/0", elapsed, running); end
        press_start();
        wait_n(10);
        n_cmp++; if (elapsed !== 8'd2) begin n_err++; $display("FAIL cd_two elapsed got %0d exp 2", elapsed); end
        wait_n(10);
        n_cmp++; if (elapsed !== 8'd1) begin n_err++; $display("FAIL cd_one elapsed got %0d exp 1", elapsed); end
        wait_n(9);
        n_cmp++; if (elapsed !== 8'd1 || done !== 1'b0 || running !== 1'b1) begin n_err++; $display("FAIL cd_prezero e=%0d done=%b run=%b exp 1/0/1", elapsed, done, running); end
        wait_n(1);
        n_cmp++; if (elapsed !== 8'd0 || done !== 1'b1 || running !== 1'b0) begin n_err++; $display("FAIL cd_zero e=%0d done=%b run=%b exp 0/1/0", elapsed, done, running); end
        wait_n(1);
        n_cmp++; if (done !== 1'b0 || elapsed !== 8'd0) begin n_err++; $display("FAIL cd_pulse done=%b e=%0d exp 0/0", done, elapsed); end
        press_start();
        wait_n(1);
        n_cmp++; if (running !== 1'b0) begin n_err++; $display("FAIL cd_start_ignored running got %b exp 0", running); end
        preset = 8'd0;
        press_reset();
        wait_n(1);
        press_start();
        n_cmp++; if (running !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL cd_preset0 run=%b done=%b exp 0/0", running, done); end
        wait_n(12);
        n_cmp++; if (elapsed !== 8'd0 || done !== 1'b0) begin n_err++; $display("FAIL cd_preset0_hold e=%0d done=%b exp 0/0", elapsed, done); end
        do_reset();
    endtask
`endif

    task automatic test_async_reset();
        do_reset();
        press_start();
        wait_n(9);
        press_lap();
        wait_n(9);
        press_lap();
        n_cmp++; if (elapsed !== 8'd2 || lap_count !== 3'd2) begin n_err++; $display("FAIL ar_pre e=%0d count=%0d exp 2/2", elapsed, lap_count); end
        lap_rd = 1'b1; @(negedge clk); lap_rd = 1'b0;
        n_cmp++; if (lap_data !== 8'd1) begin n_err++; $display("FAIL ar_head data got %0d exp 1", lap_data); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (elapsed !== 8'd0 || running !== 1'b0 || lap_data !== 8'd0) begin n_err++; $display("FAIL ar_now e=%0d run=%b data=%0d exp 0/0/0", elapsed, running, lap_data); end
        n_cmp++; if (lap_valid !== 1'b0 || lap_count !== 3'd0 || lap_overflow !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL ar_fifo v=%b c=%0d o=%b d=%b exp 0", lap_valid, lap_count, lap_overflow, done); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_run35();
        test_pause();
        test_wrap();
        test_lap_overflow();
        test_full_push_pop();
        test_start_reset_same();
`ifdef STOPWATCH_COUNTDOWN_EN
        test_countdown();
`endif
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
